swipt_freq_tuner: RTL and testbench

Digital tuning core of the SWIPT transmitter. Combines three sub-functions: a free-running 12-bit sample counter, a hill-climbing frequency search engine, and a cycle-accurate digital model of the analog link. The search engine consumes 12-bit ADC samples and emits one-cycle step requests with a direction. The top level applies these steps to the drive frequency. The search declares an optimum after repeated direction reversals.

---
 rtl/swipt_freq_tuner_if.sv | 28 ++
 rtl/swipt_freq_tuner.sv | 120 ++++++++++++
 tb/tb_swipt_freq_tuner.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/swipt_freq_tuner_if.sv
// Handshake bundle between the tuning core and the frequency/ADC side.
//   ADC_in           : unsigned ADC sample, one per cycle
//   freq_ready       : one-cycle step request
//   freq_set_up_down : step direction (1 = up, 0 = down)
//   freq_opt         : sticky optimum-found flag
// master = tuning core, slave = downstream frequency register / ADC front end.
interface swipt_freq_tuner_if #(
   parameter int unsigned CNT_W = 12
);
   logic [CNT_W-1:0] ADC_in;
   logic             freq_ready;
   logic             freq_set_up_down;
   logic             freq_opt;

   modport master (
      input  ADC_in,
      output freq_ready,
      output freq_set_up_down,
      output freq_opt
   );

   modport slave (
      output ADC_in,
      input  freq_ready,
      input  freq_set_up_down,
      input  freq_opt
   );
endinterface

// File: rtl/swipt_freq_tuner.sv
// Digital tuning core of the SWIPT transmitter: free-running sample counter,
// hill-climbing frequency search and a fixed-latency model of the analog link.
//   clk         : system clock, rising edge
//   nrst        : synchronous reset, active high
//   value       : free-running CNT_W-bit sample counter
//   bus         : ADC sample in, step request/direction and optimum flag out
//   IN_DIGITAL  : drive signal into the link model
//   OUT_DIGITAL : IN_DIGITAL delayed by NET_DELAY cycles
module swipt_freq_tuner #(
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned WINDOW    = 4096,
   parameter int unsigned REV_LIMIT = 2,
   parameter int unsigned NET_DELAY = 4
) (
   input  logic                      clk,
   input  logic                      nrst,
   output logic [CNT_W-1:0]          value,
   swipt_freq_tuner_if.master        bus,
   input  logic                      IN_DIGITAL,
   output logic                      OUT_DIGITAL
);

   localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned REV_W = $clog2(REV_LIMIT + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [REV_W-1:0] REV_MAX  = REV_W'(REV_LIMIT);

   typedef enum logic [1:0] {MEASURE, DECIDE, STEP, DONE} state_t;

   state_t               state, state_next;
   logic [WIN_W-1:0]     win_cnt;
   logic [CNT_W-1:0]     peak, prev_peak, prev_next;
   logic                 dir, dir_next;
   logic                 first, first_next;
   logic [REV_W-1:0]     rev_cnt, rev_next;
   logic [NET_DELAY-1:0] link_sr;

   // Free-running sample counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (nrst) value <= '0;
      else      value <= value + CNT_W'(1);
   end

   // Link model: plain shift register, so pulse width and edges are preserved.
   always_ff @(posedge clk) begin
      if (nrst) begin
         link_sr <= '0;
      end else begin
         link_sr[0] <= IN_DIGITAL;
         for (int i = 1; i < int'(NET_DELAY); i++) link_sr[i] <= link_sr[i-1];
      end
   end
   assign OUT_DIGITAL = link_sr[NET_DELAY-1];

   // Window counter and peak tracker; the first sample of a window reloads peak.
   always_ff @(posedge clk) begin
      if (nrst) begin
         win_cnt <= '0;
         peak    <= '0;
      end else if (state == MEASURE) begin
         if (win_cnt == '0 || bus.ADC_in > peak) peak <= bus.ADC_in;
         win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
      end
   end

   // Search state and registered outputs.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state                <= MEASURE;
         dir                  <= 1'b1;
         first                <= 1'b1;
         rev_cnt              <= '0;
         prev_peak            <= '0;
         bus.freq_ready       <= 1'b0;
         bus.freq_set_up_down <= 1'b1;
         bus.freq_opt         <= 1'b0;
      end else begin
         state                <= state_next;
         dir                  <= dir_next;
         first                <= first_next;
         rev_cnt              <= rev_next;
         prev_peak            <= prev_next;
         bus.freq_ready       <= (state == STEP);
         bus.freq_set_up_down <= dir_next;
         bus.freq_opt         <= (state == DONE);
      end
   end

   // Next-state and decision logic.
   always_comb begin
      state_next = state;
      dir_next   = dir;
      first_next = first;
      rev_next   = rev_cnt;
      prev_next  = prev_peak;
      unique case (state)
         MEASURE: begin
            if (win_cnt == WIN_LAST) state_next = DECIDE;
         end
         DECIDE: begin
            if (first) begin
               dir_next   = 1'b1;
               rev_next   = '0;
               first_next = 1'b0;
            end else if (peak > prev_peak) begin
               rev_next = '0;
            end else if (peak < prev_peak) begin
               dir_next = ~dir;
               if (rev_cnt < REV_MAX) rev_next = rev_cnt + REV_W'(1);
            end
            prev_next  = peak;
            state_next = (rev_next == REV_MAX) ? DONE : STEP;
         end
         STEP:    state_next = MEASURE;
         DONE:    state_next = DONE;
         default: state_next = MEASURE;
      endcase
   end

endmodule

// File: tb/tb_swipt_freq_tuner.sv
module tb_swipt_freq_tuner;
   localparam int unsigned CNT_W     = 12;
   localparam int unsigned WINDOW    = 16;
   localparam int unsigned REV_LIMIT = 2;
   localparam int unsigned NET_DELAY = 4;
   localparam int          PERIOD    = WINDOW + 2;

   logic             clk = 1'b0;
   logic             nrst;
   logic [CNT_W-1:0] value;
   logic             IN_DIGITAL;
   logic             OUT_DIGITAL;

   swipt_freq_tuner_if #(.CNT_W(CNT_W)) bus ();

   swipt_freq_tuner #(
      .CNT_W(CNT_W), .WINDOW(WINDOW), .REV_LIMIT(REV_LIMIT), .NET_DELAY(NET_DELAY)
   ) dut (
      .clk(clk), .nrst(nrst), .value(value), .bus(bus),
      .IN_DIGITAL(IN_DIGITAL), .OUT_DIGITAL(OUT_DIGITAL)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Advance one edge; everything is sampled and driven 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      nrst = 1'b1;
      repeat (n) tick();
      nrst = 1'b0;
      cyc  = 0;
   endtask

   task automatic test_reset();
      IN_DIGITAL = 1'b1;
      bus.ADC_in = 12'd100;
      nrst = 1'b1;
      repeat (5) tick();
      checks++; if (value !== 12'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", value); end
      checks++; if (bus.freq_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.freq_ready); end
      checks++; if (bus.freq_set_up_down !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", bus.freq_set_up_down); end
      checks++; if (bus.freq_opt !== 1'b0) begin failures++; $display("FAIL reset_opt got=%b exp=0", bus.freq_opt); end
      checks++; if (OUT_DIGITAL !== 1'b0) begin failures++; $display("FAIL reset_link got=%b exp=0", OUT_DIGITAL); end
      IN_DIGITAL = 1'b0;
      nrst = 1'b0;
      cyc  = 0;
   endtask

   task automatic test_counter();
      logic [CNT_W-1:0] exp_v;
      for (int i = 1; i <= 4096; i++) begin
         tick();
         exp_v = CNT_W'(i % 4096);
         checks++;
         if (value !== exp_v) begin
            failures++; $display("FAIL counter cyc=%0d got=%0d exp=%0d", i, value, exp_v);
         end
      end
   endtask

   task automatic test_constant();
      do_reset(2);
      bus.ADC_in = 12'd100;
      for (int w = 0; w < 100; w++) begin
         for (int t = 1; t <= PERIOD; t++) begin
            tick();
            checks++;
            if (bus.freq_ready !== 1'(t == PERIOD)) begin
               failures++; $display("FAIL const_ready cyc=%0d got=%b exp=%b", cyc, bus.freq_ready, (t == PERIOD));
            end
            if (t == PERIOD) begin
               checks++;
               if (bus.freq_set_up_down !== 1'b1) begin
                  failures++; $display("FAIL const_dir win=%0d got=%b exp=1", w, bus.freq_set_up_down);
               end
            end
            checks++;
            if (bus.freq_opt !== 1'b0) begin
               failures++; $display("FAIL const_opt cyc=%0d got=%b exp=0", cyc, bus.freq_opt);
            end
         end
      end
   endtask

   task automatic test_hill();
      int   prof [7];
      logic dirs [6];
      logic exp_rdy, exp_opt;
      prof = '{100, 200, 300, 250, 280, 260, 240};
      dirs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset(2);
      for (int w = 0; w < 7; w++) begin
         bus.ADC_in = CNT_W'(prof[w]);
         for (int t = 1; t <= PERIOD; t++) begin
            tick();
            exp_rdy = (t == PERIOD) && (w < 6);
            exp_opt = (cyc >= 7 * PERIOD);
            checks++;
            if (bus.freq_ready !== exp_rdy) begin
               failures++; $display("FAIL hill_ready cyc=%0d got=%b exp=%b", cyc, bus.freq_ready, exp_rdy);
            end
            if (exp_rdy) begin
               checks++;
               if (bus.freq_set_up_down !== dirs[w]) begin
                  failures++; $display("FAIL hill_dir win=%0d got=%b exp=%b", w, bus.freq_set_up_down, dirs[w]);
               end
            end
            checks++;
            if (bus.freq_opt !== exp_opt) begin
               failures++; $display("FAIL hill_opt cyc=%0d got=%b exp=%b", cyc, bus.freq_opt, exp_opt);
            end
         end
      end
   endtask

   task automatic test_sticky();
      int   prof [2];
      logic dirs [2];
      for (int w = 0; w < 10; w++) begin
         bus.ADC_in = CNT_W'(400 + 100 * w);
         for (int t = 1; t <= PERIOD; t++) begin
            tick();
            checks++;
            if (bus.freq_ready !== 1'b0) begin
               failures++; $display("FAIL sticky_ready cyc=%0d got=%b exp=0", cyc, bus.freq_ready);
            end
            checks++;
            if (bus.freq_opt !== 1'b1) begin
               failures++; $display("FAIL sticky_opt cyc=%0d got=%b exp=1", cyc, bus.freq_opt);
            end
         end
      end
      repeat (7) tick();
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      cyc  = 0;
      checks++; if (bus.freq_opt !== 1'b0) begin failures++; $display("FAIL rst_opt got=%b exp=0", bus.freq_opt); end
      checks++; if (bus.freq_set_up_down !== 1'b1) begin failures++; $display("FAIL rst_dir got=%b exp=1", bus.freq_set_up_down); end
      checks++; if (value !== 12'd0) begin failures++; $display("FAIL rst_value got=%0d exp=0", value); end
      prof = '{50, 40};
      dirs = '{1'b1, 1'b0};
      for (int w = 0; w < 2; w++) begin
         bus.ADC_in = CNT_W'(prof[w]);
         for (int t = 1; t <= PERIOD; t++) begin
            tick();
            checks++;
            if (bus.freq_ready !== 1'(t == PERIOD)) begin
               failures++; $display("FAIL restart_ready cyc=%0d got=%b exp=%b", cyc, bus.freq_ready, (t == PERIOD));
            end
            if (t == PERIOD) begin
               checks++;
               if (bus.freq_set_up_down !== dirs[w]) begin
                  failures++; $display("FAIL restart_dir win=%0d got=%b exp=%b", w, bus.freq_set_up_down, dirs[w]);
               end
            end
         end
      end
   endtask

   task automatic test_equal();
      int   prof [4];
      logic dirs [4];
      prof = '{300, 200, 200, 200};
      dirs = '{1'b1, 1'b0, 1'b0, 1'b0};
      do_reset(2);
      for (int w = 0; w < 4; w++) begin
         bus.ADC_in = CNT_W'(prof[w]);
         for (int t = 1; t <= PERIOD; t++) begin
            tick();
            checks++;
            if (bus.freq_ready !== 1'(t == PERIOD)) begin
               failures++; $display("FAIL equal_ready cyc=%0d got=%b exp=%b", cyc, bus.freq_ready, (t == PERIOD));
            end
            if (t == PERIOD) begin
               checks++;
               if (bus.freq_set_up_down !== dirs[w]) begin
                  failures++; $display("FAIL equal_dir win=%0d got=%b exp=%b", w, bus.freq_set_up_down, dirs[w]);
               end
            end
            checks++;
            if (bus.freq_opt !== 1'b0) begin
               failures++; $display("FAIL equal_opt cyc=%0d got=%b exp=0", cyc, bus.freq_opt);
            end
         end
      end
   endtask

   task automatic test_link();
      logic exp_o;
      do_reset(2);
      IN_DIGITAL = 1'b0;
      repeat (3) tick();
      IN_DIGITAL = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 3) IN_DIGITAL = 1'b0;
         exp_o = (t >= 4) && (t <= 6);
         checks++;
         if (OUT_DIGITAL !== exp_o) begin
            failures++; $display("FAIL link_pulse t=%0d got=%b exp=%b", t, OUT_DIGITAL, exp_o);
         end
      end
      IN_DIGITAL = 1'b1;
      repeat (2) tick();
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      IN_DIGITAL = 1'b0;
      for (int t = 0; t < 8; t++) begin
         checks++;
         if (OUT_DIGITAL !== 1'b0) begin
            failures++; $display("FAIL link_flush t=%0d got=%b exp=0", t, OUT_DIGITAL);
         end
         tick();
      end
   endtask

   initial begin
      nrst       = 1'b1;
      IN_DIGITAL = 1'b0;
      bus.ADC_in = '0;
      test_reset();
      test_counter();
      test_constant();
      test_hill();
      test_sticky();
      test_equal();
      test_link();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
